// File: rtl/layer_pass_sequencer_if.sv
// Engine-facing port bundle of the layer pass sequencer: pixel feed plus engine control/status.
// Handshake: a pixel beat happens on a rising edge where feed_valid=1 and feed_ready=1. While
// feed_valid=1 the offered coordinates stay stable until that beat. feed_ready may toggle freely.
interface layer_pass_sequencer_if;
    logic       feed_valid;
    logic       feed_ready;
    logic [7:0] feed_col;
    logic [7:0] feed_row;
    logic [9:0] feed_pass;
    logic       engine_rst;
    logic       engine_valid_out;

    modport master (
        output feed_valid, feed_col, feed_row, feed_pass, engine_rst,
        input  feed_ready, engine_valid_out
    );

    modport slave (
        input  feed_valid, feed_col, feed_row, feed_pass, engine_rst,
        output feed_ready, engine_valid_out
    );
endinterface

// File: rtl/layer_pass_sequencer.sv
// Sequences one conv layer: for each input-channel pass it clears the engine, streams a WxW
// pixel raster, then waits for the expected number of engine outputs (with a drain watchdog).
module layer_pass_sequencer #(
    parameter int MAX_WIDTH = 224,
    parameter int TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             cfg_width,
    input  logic [9:0]             cfg_passes,
    input  logic                   cfg_pool,
    layer_pass_sequencer_if.master eng,
    output logic                   busy,
    output logic                   pass_done,
    output logic                   layer_done,
    output logic                   err_cfg,
    output logic                   err_timeout,
    output logic [15:0]            out_count,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int IW = $clog2(TIMEOUT) + 1;
    // Timeout fires on the edge where the idle count would step to TIMEOUT-1.
    localparam logic [IW-1:0] TO_LIMIT = IW'(TIMEOUT - 2);

    state_t        state_q;
    logic [7:0]    w_q, col_q, row_q;
    logic [9:0]    p_q, pass_q;
    logic          pool_q;
    logic [15:0]   cnt_q;
    logic [IW-1:0] idle_q;
    logic          erst_q, err_cfg_q, err_to_q;

    logic          cfg_ok;
    logic [7:0]    last_idx;
    logic [15:0]   exp_cnt;
    logic [15:0]   w16, h16;

    assign cfg_ok = (cfg_width >= 8'd2) && ({24'd0, cfg_width} <= 32'(MAX_WIDTH))
                 && (cfg_passes != 10'd0) && !(cfg_pool && cfg_width[0]);
    assign last_idx = w_q - 8'd1;

    always_comb begin
        w16     = {8'd0, w_q};
        h16     = {9'd0, w_q[7:1]};
        exp_cnt = pool_q ? (h16 * h16) : (w16 * w16);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            w_q       <= 8'd0;
            p_q       <= 10'd0;
            pool_q    <= 1'b0;
            col_q     <= 8'd0;
            row_q     <= 8'd0;
            pass_q    <= 10'd0;
            cnt_q     <= 16'd0;
            idle_q    <= '0;
            erst_q    <= 1'b0;
            err_cfg_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            err_cfg_q <= 1'b0;
            erst_q    <= 1'b1;
            // Outputs only count while a pass is streaming or draining, saturating at the expectation.
            if ((state_q == S_STREAM || state_q == S_DRAIN) && eng.engine_valid_out
                && (cnt_q != exp_cnt)) begin
                cnt_q <= cnt_q + 16'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            w_q      <= cfg_width;
                            p_q      <= cfg_passes;
                            pool_q   <= cfg_pool;
                            err_to_q <= 1'b0;
                            pass_q   <= 10'd0;
                            cnt_q    <= 16'd0;
                            col_q    <= 8'd0;
                            row_q    <= 8'd0;
                            erst_q   <= 1'b0;
                            state_q  <= S_CLEAR;
                        end else begin
                            err_cfg_q <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    cnt_q   <= 16'd0;
                    col_q   <= 8'd0;
                    row_q   <= 8'd0;
                    state_q <= S_STREAM;
                end
                S_STREAM: begin
                    if (eng.feed_ready) begin
                        if (col_q == last_idx) begin
                            col_q <= 8'd0;
                            if (row_q == last_idx) begin
                                row_q   <= 8'd0;
                                idle_q  <= '0;
                                state_q <= S_DRAIN;
                            end else begin
                                row_q <= row_q + 8'd1;
                            end
                        end else begin
                            col_q <= col_q + 8'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == exp_cnt) begin
                        if (pass_q < p_q - 10'd1) begin
                            pass_q  <= pass_q + 10'd1;
                            cnt_q   <= 16'd0;
                            erst_q  <= 1'b0;
                            state_q <= S_CLEAR;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end else if (eng.engine_valid_out) begin
                        idle_q <= '0;
                    end else if (idle_q == TO_LIMIT) begin
                        err_to_q <= 1'b1;
                        pass_q   <= 10'd0;
                        state_q  <= S_IDLE;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end
                S_DONE: begin
                    pass_q  <= 10'd0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign eng.feed_valid = (state_q == S_STREAM);
    assign eng.feed_col   = col_q;
    assign eng.feed_row   = row_q;
    assign eng.feed_pass  = pass_q;
    assign eng.engine_rst = erst_q;

    assign busy        = (state_q != S_IDLE);
    assign pass_done   = (state_q == S_DRAIN) && (cnt_q == exp_cnt);
    assign layer_done  = (state_q == S_DONE);
    assign err_cfg     = err_cfg_q;
    assign err_timeout = err_to_q;
    assign out_count   = cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_layer_pass_sequencer.sv
// Directed bench for layer_pass_sequencer: config table plus hand-written multi-cycle runs.
module tb_layer_pass_sequencer;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start;
  logic [7:0]  cfg_width;
  logic [9:0]  cfg_passes;
  logic        cfg_pool;
  logic        busy, pass_done, layer_done, err_cfg, err_timeout;
  logic [15:0] out_count;
  logic [2:0]  dbg_state;

  layer_pass_sequencer_if eng_if();

  layer_pass_sequencer #(.MAX_WIDTH(224), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_width   (cfg_width),
    .cfg_passes  (cfg_passes),
    .cfg_pool    (cfg_pool),
    .eng         (eng_if.master),
    .busy        (busy),
    .pass_done   (pass_done),
    .layer_done  (layer_done),
    .err_cfg     (err_cfg),
    .err_timeout (err_timeout),
    .out_count   (out_count),
    .dbg_state   (dbg_state)
  );

  typedef struct {
    logic [7:0] w;
    logic [9:0] p;
    logic       pool;
    logic       exp_err;
  } cfg_vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats, first_beat, last_beat, pd_cnt, pd_cyc, ld_cnt, ld_cyc, erst_cnt;
  int echo_mode;
  logic [2:0] pipe;
  bit toggle_ready;
  int m_w, m_col, m_row, m_pass, m_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: checks the offered pixel against the raster model, runs the echo engine model.
  task automatic tick();
    logic beat, echo_bit;
    beat = eng_if.feed_valid && eng_if.feed_ready;
    echo_bit = 1'b0;
    if (eng_if.feed_valid) begin
      chk("feed_col", eng_if.feed_col, m_col);
      chk("feed_row", eng_if.feed_row, m_row);
      chk("feed_pass", eng_if.feed_pass, m_pass);
    end
    if (beat) begin
      beats++;
      if (first_beat < 0) first_beat = cyc + 1;
      last_beat = cyc + 1;
      echo_bit = (echo_mode == 1) || (echo_mode == 2 && m_col[0] && m_row[0]);
      if (m_col == m_w - 1) begin
        m_col = 0;
        m_row++;
      end else begin
        m_col++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    pipe = {pipe[1:0], echo_bit};
    if (echo_mode != 0) eng_if.engine_valid_out = pipe[2];
    if (rst && !eng_if.engine_rst) begin
      erst_cnt++;
      m_col = 0;
      m_row = 0;
    end
    if (pass_done) begin
      pd_cnt++;
      pd_cyc = cyc;
      chk("pass_out_count", out_count, m_e);
      m_pass++;
    end
    if (layer_done) begin
      ld_cnt++;
      ld_cyc = cyc;
    end
    if (toggle_ready) eng_if.feed_ready = !eng_if.feed_ready;
  endtask

  task automatic start_run(input int w, input int p, input bit pool, input int mode);
    m_w = w; m_col = 0; m_row = 0; m_pass = 0;
    m_e = pool ? (w / 2) * (w / 2) : w * w;
    beats = 0; first_beat = -1; last_beat = -1;
    pd_cnt = 0; pd_cyc = -1; ld_cnt = 0; ld_cyc = -1; erst_cnt = 0;
    echo_mode = mode; pipe = 3'b000; eng_if.engine_valid_out = 1'b0;
    cfg_width = w[7:0]; cfg_passes = p[9:0]; cfg_pool = pool;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(name, busy, 0);
  endtask

  initial begin
    cfg_vec_t vecs[8];
    int n;
    bit bad;

    rst = 1'b0; start = 1'b0; cfg_width = 8'd0; cfg_passes = 10'd0; cfg_pool = 1'b0;
    eng_if.feed_ready = 1'b0; eng_if.engine_valid_out = 1'b0;
    toggle_ready = 1'b0; echo_mode = 0; pipe = 3'b000;
    m_w = 4; m_col = 0; m_row = 0; m_pass = 0; m_e = 16;
    beats = 0; first_beat = -1; last_beat = -1;
    pd_cnt = 0; pd_cyc = -1; ld_cnt = 0; ld_cyc = -1; erst_cnt = 0;

    // Reset state
    tick(); tick();
    chk("rst_feed_valid", eng_if.feed_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pass_done", pass_done, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_err_cfg", err_cfg, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_feed_col", eng_if.feed_col, 0);
    chk("rst_feed_row", eng_if.feed_row, 0);
    chk("rst_feed_pass", eng_if.feed_pass, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_engine_rst", eng_if.engine_rst, 0);
    rst = 1'b1;
    tick();
    chk("post_rst_engine_rst", eng_if.engine_rst, 1);
    chk("post_rst_busy", busy, 0);

    // Config acceptance table
    vecs[0] = '{8'd5,   10'd1,    1'b1, 1'b1};
    vecs[1] = '{8'd0,   10'd1,    1'b0, 1'b1};
    vecs[2] = '{8'd4,   10'd0,    1'b0, 1'b1};
    vecs[3] = '{8'd1,   10'd1,    1'b0, 1'b1};
    vecs[4] = '{8'd225, 10'd1,    1'b0, 1'b1};
    vecs[5] = '{8'd224, 10'd1,    1'b1, 1'b0};
    vecs[6] = '{8'd5,   10'd3,    1'b0, 1'b0};
    vecs[7] = '{8'd2,   10'd1023, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      m_col = 0; m_row = 0; m_pass = 0;
      cfg_width = vecs[i].w; cfg_passes = vecs[i].p; cfg_pool = vecs[i].pool;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("cfg_err", err_cfg, vecs[i].exp_err);
      chk("cfg_busy", busy, !vecs[i].exp_err);
      tick();
      chk("cfg_err_pulse", err_cfg, 0);
      chk("cfg_busy_hold", busy, !vecs[i].exp_err);
      if (!vecs[i].exp_err) begin
        rst = 1'b0; tick(); rst = 1'b1; tick();
      end
    end

    // Single pass, W=4, no pooling, engine echoes each beat 3 cycles later
    eng_if.feed_ready = 1'b1;
    start_run(4, 1, 1'b0, 1);
    wait_idle(200, "l1_complete");
    chk("l1_beats", beats, 16);
    chk("l1_beat_span", last_beat - first_beat, 15);
    chk("l1_pass_done_cnt", pd_cnt, 1);
    chk("l1_pass_done_cyc", pd_cyc, last_beat + 3);
    chk("l1_layer_done_cnt", ld_cnt, 1);
    chk("l1_layer_done_cyc", ld_cyc, pd_cyc + 1);
    chk("l1_engine_rst_lows", erst_cnt, 1);

    // Two pooled passes with feed_ready toggling
    toggle_ready = 1'b1;
    start_run(4, 2, 1'b1, 2);
    wait_idle(400, "l2_complete");
    chk("l2_beats", beats, 32);
    chk("l2_engine_rst_lows", erst_cnt, 2);
    chk("l2_pass_done_cnt", pd_cnt, 2);
    chk("l2_layer_done_cnt", ld_cnt, 1);
    toggle_ready = 1'b0;
    eng_if.feed_ready = 1'b1;

    // Count saturates during STREAM; last beat and an output coincide; completion on DRAIN entry
    start_run(2, 1, 1'b1, 1);
    wait_idle(100, "sat_complete");
    chk("sat_beats", beats, 4);
    chk("sat_pass_done_cyc", pd_cyc, last_beat);
    chk("sat_layer_done_cnt", ld_cnt, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("idle_ignores_outputs", out_count, 1);
    echo_mode = 0;
    eng_if.engine_valid_out = 1'b0;

    // Drain watchdog: only 3 of 4 outputs arrive
    start_run(2, 1, 1'b0, 0);
    n = 0;
    while (dbg_state != ST_DRAIN && n < 20) begin
      tick();
      n++;
    end
    chk("to_reach_drain", dbg_state, ST_DRAIN);
    eng_if.engine_valid_out = 1'b1;
    tick(); tick(); tick();
    eng_if.engine_valid_out = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (err_timeout || !busy) bad = 1'b1;
    end
    chk("to_not_early", bad, 0);
    tick();
    chk("to_err_timeout", err_timeout, 1);
    chk("to_idle", dbg_state, ST_IDLE);
    chk("to_out_count", out_count, 3);
    chk("to_no_pass_done", pd_cnt, 0);
    tick();
    chk("to_sticky", err_timeout, 1);
    chk("to_no_layer_done", ld_cnt, 0);
    start_run(2, 1, 1'b0, 1);
    chk("to_cleared_by_start", err_timeout, 0);
    wait_idle(100, "to_rerun_complete");
    chk("to_rerun_layer_done", ld_cnt, 1);

    // Reset in the middle of pass 1
    start_run(4, 2, 1'b1, 2);
    n = 0;
    while (!(eng_if.feed_valid && eng_if.feed_pass == 10'd1 && eng_if.feed_col == 8'd2) && n < 200) begin
      tick();
      n++;
    end
    chk("mid_reach_pass1", eng_if.feed_pass, 1);
    echo_mode = 0;
    eng_if.engine_valid_out = 1'b0;
    rst = 1'b0;
    tick();
    chk("mid_rst_feed_valid", eng_if.feed_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_col_row", {eng_if.feed_col, eng_if.feed_row}, 0);
    chk("mid_rst_pass", eng_if.feed_pass, 0);
    chk("mid_rst_out_count", out_count, 0);
    chk("mid_rst_engine_rst", eng_if.engine_rst, 0);
    chk("mid_rst_state", dbg_state, ST_IDLE);
    rst = 1'b1;
    tick();
    chk("mid_rel_engine_rst", eng_if.engine_rst, 1);
    start_run(4, 1, 1'b0, 1);
    n = 0;
    while (dbg_state != ST_STREAM && n < 10) begin
      tick();
      n++;
    end
    chk("mid_restart_col", eng_if.feed_col, 0);
    chk("mid_restart_row", eng_if.feed_row, 0);
    chk("mid_restart_pass", eng_if.feed_pass, 0);
    wait_idle(200, "mid_restart_complete");
    chk("mid_restart_beats", beats, 16);
    chk("mid_restart_layer_done", ld_cnt, 1);

    // start with a different config during STREAM is ignored
    start_run(4, 1, 1'b0, 1);
    tick(); tick(); tick();
    cfg_width = 8'd2; cfg_pool = 1'b1; cfg_passes = 10'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_still_stream", dbg_state, ST_STREAM);
    wait_idle(200, "ign_complete");
    chk("ign_beats", beats, 16);
    chk("ign_pass_done_cnt", pd_cnt, 1);
    chk("ign_layer_done_cnt", ld_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/layer_pass_sequencer.md
LAYER_PASS_SEQUENCER -- requirements
Module: layer_pass_sequencer

Interface
REQ-001 Parameter MAX_WIDTH, default 224: largest feature-map side accepted.
REQ-002 Parameter TIMEOUT, default 1024: idle-cycle limit while waiting for engine outputs.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to run a layer with the current cfg_* values.
REQ-006 cfg_width  input  8  feature-map side W.
REQ-007 cfg_passes  input  10  input-channel passes P.
REQ-008 cfg_pool  input  1  1 = engine max-pools 2x2, so output count per pass is (W/2)^2.
REQ-009 feed_ready  input  1  engine can accept a pixel this cycle.
REQ-010 engine_valid_out  input  1  valid_out of the conv/bias/pool control chain.
REQ-011 feed_valid  output  1  pixel offered to engine.
REQ-012 feed_col, feed_row  output  8 each  coordinates of the offered pixel.
REQ-013 feed_pass  output  10  current pass index.
REQ-014 engine_rst  output  1  active-low clear for the engine control chain.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 pass_done, layer_done  output  1 each  one-cycle completion pulses.
REQ-017 err_cfg, err_timeout  output  1 each  error flags.
REQ-018 out_count  output  16  engine outputs counted in the current pass.

Function
REQ-019 Registered FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-020 In IDLE, start with a valid config latches W, P and pool, clears err_timeout, and moves to CLEAR.
REQ-021 Valid config: 2<=W<=MAX_WIDTH, P>=1, and W even if pool=1.
REQ-022 On start with an invalid config, the block stays IDLE and pulses err_cfg high for exactly one cycle.
REQ-023 start outside IDLE is ignored; cfg_* changes after latching have no effect.
REQ-024 CLEAR lasts exactly one cycle with engine_rst=0, clears out_count, col and row, then moves to STREAM; engine_rst=1 in every other state.
REQ-025 In STREAM, feed_valid=1; a beat occurs on a cycle with feed_valid=1 and feed_ready=1.
REQ-026 Counters advance only on a beat: col increments; at col=W-1, col wraps to 0 and row increments.
REQ-027 When feed_ready=0, col and row hold, and feed_valid stays 1.
REQ-028 The beat at (W-1, W-1) moves the FSM to DRAIN on the next cycle; feed_valid=0 outside STREAM.
REQ-029 out_count increments on every engine_valid_out in STREAM or DRAIN.
REQ-030 out_count saturates at E, where E = (W/2)^2 if pool=1, else W*W.
REQ-031 In DRAIN, once out_count=E: pass_done pulses for one cycle.
REQ-032 On that completion, if feed_pass<P-1, feed_pass increments and the FSM goes to CLEAR; otherwise the FSM goes to DONE.
REQ-033 DONE lasts one cycle with layer_done=1, then moves to IDLE; feed_pass returns to 0.
REQ-034 If out_count=E is already reached on entry to DRAIN, completion occurs in the first DRAIN cycle.
REQ-035 Watchdog: in DRAIN, an idle counter clears on each engine_valid_out and increments otherwise.
REQ-036 When the idle counter reaches TIMEOUT-1, err_timeout is set (sticky), the FSM goes to IDLE, and no pass_done or layer_done is produced.
REQ-037 engine_valid_out in IDLE or CLEAR is ignored.
REQ-038 Simultaneous last beat and engine_valid_out: both take effect in the same cycle.

Reset
REQ-039 rst=0 at a clock edge forces IDLE regardless of state, including mid-STREAM or mid-DRAIN.
REQ-040 During reset: feed_valid=0, busy=0, pass_done=0, layer_done=0, err_cfg=0, err_timeout=0.
REQ-041 During reset: feed_col=0, feed_row=0, feed_pass=0, out_count=0, engine_rst=0.
REQ-042 The first cycle after reset release has engine_rst=1.

Verification
REQ-043 W=4, P=1, pool=0, feed_ready=1, engine echoes each beat 3 cycles later -> 16 beats in 16 consecutive cycles, out_count=16, one pass_done, then layer_done next cycle.
REQ-044 W=4, P=2, pool=1, feed_ready toggling 1/0 -> 32 beats with coordinates held on stalls, engine_rst low exactly twice, pass_done twice (out_count=4 each), layer_done once.
REQ-045 start with W=5, pool=1, or W=0, or P=0 -> err_cfg single pulse each, busy stays 0.
REQ-046 W=2, P=1, engine supplies only 3 outputs, TIMEOUT=16 -> err_timeout set 15 cycles after the last output, FSM IDLE, no layer_done; next valid start clears err_timeout.
REQ-047 rst=0 mid-STREAM of pass 1 -> all outputs at reset values next cycle; a new start then runs from pass 0, (0,0).
REQ-048 start pulsed during STREAM with different cfg -> ignored, original layer completes unchanged.
